// File: rtl/status_cond_unit_pkg.sv
// Shared definitions for the status flags and condition codes.
// Used by the ALU (flag packing), the status/condition unit and the
// branch unit (condition evaluation through cond_check).
package status_cond_unit_pkg;

  // Flag bit positions inside the packed {Z,C,N,V} status word
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Instruction condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/status_cond_unit_cond_check.sv
// cond_check: purely combinational condition evaluator.
// Ports:
//   flags - packed status flags {Z,C,N,V}
//   cond  - instruction condition field
//   pass  - 1 when the instruction is to execute
module cond_check
  import status_cond_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// status_cond_unit: holds the architectural status flags and decides
// whether the ID-stage instruction executes.
// Parameters:
//   BYPASS_EN   - nonzero: flags produced in EXE this cycle feed condition
//                 evaluation directly (no stall needed for dependent ops)
//   RESET_FLAGS - status value loaded by reset
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   alu_status  - ALU flags {Z,C,N,V} of the EXE-stage instruction
//   exe_valid   - EXE-stage instruction is real (not a bubble)
//   exe_s       - EXE-stage instruction writes flags
//   freeze      - global pipeline hold
//   id_cond     - condition field of the ID-stage instruction
//   status      - registered status flags
//   cond_pass   - ID-stage instruction executes (combinational)
//   flag_wr     - one-cycle pulse after the status register was written
module status_cond_unit
  import status_cond_unit_pkg::*;
#(
  parameter int         BYPASS_EN   = 1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] alu_status,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic       freeze,
  input  logic [3:0] id_cond,
  output logic [3:0] status,
  output logic       cond_pass,
  output logic       flag_wr
);

  localparam bit BYPASS = (BYPASS_EN != 0);

  logic       flag_src;
  logic       wr_en;
  logic [3:0] eff_flags;

  // exe_s only counts for a real instruction
  assign flag_src = exe_valid & exe_s;
  assign wr_en    = flag_src & ~freeze;

  // Forwarding does not depend on freeze: a held instruction in EXE still
  // owns the newest flags, so ID must see them.
  assign eff_flags = (BYPASS && flag_src) ? alu_status : status;

  cond_check u_cond_check (
    .flags (eff_flags),
    .cond  (id_cond),
    .pass  (cond_pass)
  );

  // Status register stage; reset overrides any concurrent write
  always_ff @(posedge clk) begin
    if (rst) begin
      status  <= RESET_FLAGS;
      flag_wr <= 1'b0;
    end else begin
      if (wr_en) begin
        status <= alu_status;
      end
      flag_wr <= wr_en;
    end
  end

endmodule

// File: tb/tb_status_cond_unit.sv
// Testbench for status_cond_unit: directed sequences, a condition table,
// a full cond/flag sweep and randomized traffic against a reference model.
module tb_status_cond_unit;
  import status_cond_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_status;
  logic       exe_valid;
  logic       exe_s;
  logic       freeze;
  logic [3:0] id_cond;
  logic [3:0] status;
  logic       cond_pass;
  logic       flag_wr;

  int checks = 0;
  int errors = 0;

  status_cond_unit #(
    .BYPASS_EN   (1),
    .RESET_FLAGS (4'b0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_status (alu_status),
    .exe_valid  (exe_valid),
    .exe_s      (exe_s),
    .freeze     (freeze),
    .id_cond    (id_cond),
    .status     (status),
    .cond_pass  (cond_pass),
    .flag_wr    (flag_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Condition truth from the condition table: codes come in pairs, the odd
  // member being the negation of the even one.
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v, base;
    z  = f[3];
    cy = f[2];
    n  = f[1];
    v  = f[0];
    case (c >> 1)
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] m_status;
  logic       m_fw;

  initial begin
    rst = 1'b1; alu_status = 4'h0; exe_valid = 1'b0; exe_s = 1'b0;
    freeze = 1'b0; id_cond = COND_EQ;

    // Reset state
    step();
    chk("reset_status", status, 4'b0000);
    chk("reset_flag_wr", {3'b0, flag_wr}, 4'h0);
    chk("reset_eq_pass", {3'b0, cond_pass}, 4'h0);
    rst = 1'b0;

    // Flag write with same-cycle bypass
    alu_status = 4'b1000; exe_valid = 1'b1; exe_s = 1'b1; id_cond = COND_EQ;
    #1;
    chk("bypass_eq_pass", {3'b0, cond_pass}, 4'h1);
    step();
    chk("write_status", status, 4'b1000);
    chk("write_flag_wr", {3'b0, flag_wr}, 4'h1);
    exe_valid = 1'b0; exe_s = 1'b0;
    step();
    chk("flag_wr_pulse_end", {3'b0, flag_wr}, 4'h0);

    // Freeze holds the register for three cycles
    alu_status = 4'b0011; exe_valid = 1'b1; exe_s = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_status", status, 4'b1000);
      chk("freeze_flag_wr", {3'b0, flag_wr}, 4'h0);
    end
    freeze = 1'b0;
    step();
    chk("unfreeze_status", status, 4'b0011);
    chk("unfreeze_flag_wr", {3'b0, flag_wr}, 4'h1);
    exe_valid = 1'b0; exe_s = 1'b0;

    // Bubble carrying an S bit is ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    exe_valid = 1'b0; exe_s = 1'b1; alu_status = 4'b1111; id_cond = COND_NE;
    #1;
    chk("bubble_ne_pass", {3'b0, cond_pass}, 4'h1);
    step();
    chk("bubble_status", status, 4'b0000);
    chk("bubble_flag_wr", {3'b0, flag_wr}, 4'h0);

    // Reset wins over a concurrent flag write
    alu_status = 4'b0011; exe_valid = 1'b1; exe_s = 1'b1;
    step();
    rst = 1'b1; alu_status = 4'b0100;
    step();
    chk("rst_wins_status", status, 4'b0000);
    chk("rst_wins_flag_wr", {3'b0, flag_wr}, 4'h0);
    rst = 1'b0; exe_valid = 1'b0; exe_s = 1'b0;
    #1;
    id_cond = COND_EQ;
    #1;
    chk("post_rst_eq_pass", {3'b0, cond_pass}, 4'h0);

    // Hand-picked condition table (flags {Z,C,N,V}), applied through bypass
    vecs[0]  = '{COND_GE, 4'b0011, 1'b1};
    vecs[1]  = '{COND_GE, 4'b0010, 1'b0};
    vecs[2]  = '{COND_LT, 4'b0010, 1'b1};
    vecs[3]  = '{COND_LT, 4'b0011, 1'b0};
    vecs[4]  = '{COND_HI, 4'b0100, 1'b1};
    vecs[5]  = '{COND_HI, 4'b1100, 1'b0};
    vecs[6]  = '{COND_LS, 4'b1100, 1'b1};
    vecs[7]  = '{COND_LS, 4'b0100, 1'b0};
    vecs[8]  = '{COND_GT, 4'b0000, 1'b1};
    vecs[9]  = '{COND_GT, 4'b1000, 1'b0};
    vecs[10] = '{COND_LE, 4'b0010, 1'b1};
    vecs[11] = '{COND_LE, 4'b0011, 1'b0};
    vecs[12] = '{COND_AL, 4'b0000, 1'b1};
    vecs[13] = '{COND_NV, 4'b1111, 1'b0};
    vecs[14] = '{COND_MI, 4'b0010, 1'b1};
    vecs[15] = '{COND_VC, 4'b0001, 1'b0};
    freeze = 1'b1; exe_valid = 1'b1; exe_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id_cond = vecs[i].cond; alu_status = vecs[i].flags;
      #1;
      chk($sformatf("table_%0d", i), {3'b0, cond_pass}, {3'b0, vecs[i].exp});
    end

    // Full sweep of condition codes against all flag values
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        id_cond = 4'(c); alu_status = 4'(f);
        #1;
        chk($sformatf("sweep_c%0d_f%0h", c, f), {3'b0, cond_pass},
            {3'b0, model_pass(4'(c), 4'(f))});
      end
    end
    step();
    freeze = 1'b0; exe_valid = 1'b0; exe_s = 1'b0;

    // Randomized traffic against the reference model
    rst = 1'b1;
    step();
    m_status = 4'b0000; m_fw = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 31) == 0);
      alu_status = 4'($urandom);
      exe_valid  = 1'($urandom);
      exe_s      = 1'($urandom);
      freeze     = ($urandom_range(0, 3) == 0);
      id_cond    = 4'($urandom);
      #1;
      chk("rand_cond_pass", {3'b0, cond_pass},
          {3'b0, model_pass(id_cond, (exe_valid && exe_s) ? alu_status : m_status)});
      if (rst) begin
        m_status = 4'b0000;
        m_fw     = 1'b0;
      end else if (exe_valid && exe_s && !freeze) begin
        m_status = alu_status;
        m_fw     = 1'b1;
      end else begin
        m_fw = 1'b0;
      end
      step();
      chk("rand_status", status, m_status);
      chk("rand_flag_wr", {3'b0, flag_wr}, {3'b0, m_fw});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
